// File: rtl/dcache_wb_ctrl_if.sv
// CPU request/response and line-wide backing-memory channels of the data cache controller.
// The controller takes the slave view; the CPU and memory side take the master view.
interface dcache_wb_ctrl_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
);
  logic                     is_input_valid;
  logic [ADDR_W-1:0]        addr;
  logic                     mem_read;
  logic                     mem_write;
  logic [31:0]              din;
  logic                     is_ready;
  logic                     is_output_valid;
  logic [31:0]              dout;
  logic                     is_hit;

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_we;
  logic [ADDR_W-1:0]        mem_req_addr;
  logic [LINE_WORDS*32-1:0] mem_req_wdata;
  logic                     mem_resp_valid;
  logic [LINE_WORDS*32-1:0] mem_resp_rdata;

  modport slave (
    input  is_input_valid, addr, mem_read, mem_write, din,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output is_ready, is_output_valid, dout, is_hit,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  modport master (
    output is_input_valid, addr, mem_read, mem_write, din,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  is_ready, is_output_valid, dout, is_hit,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller; hits complete one cycle after accept.
// Misses evict a dirty victim, refill from backing memory, then re-compare; one memory request in flight.
module dcache_wb_ctrl #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  dcache_wb_ctrl_if.slave   bus,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, WAIT_FILL} state_t;
  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:2]   req_addr_q, req_addr_d;
  logic [31:0]         req_din_q, req_din_d;
  logic                req_we_q, req_we_d;
  logic                first_q, first_d;
  logic                sent_q, sent_d;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_d [NUM_SETS];
  line_t               data_q [NUM_SETS];
  line_t               data_d [NUM_SETS];
  logic [31:0]         hit_count_q, hit_count_d;
  logic [31:0]         miss_count_q, miss_count_d;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             lookup_hit;

  assign req_off    = req_addr_q[OFF_W+1:2];
  assign req_idx    = req_addr_q[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag    = req_addr_q[ADDR_W-1:OFF_W+IDX_W+2];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_din_d    = req_din_q;
    req_we_d     = req_we_q;
    first_d      = first_q;
    sent_d       = sent_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;

    bus.is_ready        = 1'b0;
    bus.is_output_valid = 1'b0;
    bus.is_hit          = 1'b0;
    bus.dout            = 32'd0;
    bus.mem_req_valid   = 1'b0;
    bus.mem_req_we      = 1'b0;
    bus.mem_req_addr    = '0;
    bus.mem_req_wdata   = '0;

    case (state_q)
      IDLE: begin
        bus.is_ready = 1'b1;
        if (bus.is_input_valid && (bus.mem_read || bus.mem_write)) begin
          req_addr_d = bus.addr[ADDR_W-1:2];
          req_din_d  = bus.din;
          req_we_d   = bus.mem_write;
          first_d    = 1'b1;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        if (lookup_hit) begin
          bus.is_output_valid = 1'b1;
          bus.is_hit          = first_q;
          bus.dout            = data_q[req_idx][req_off];
          if (req_we_q) begin
            data_d[req_idx][req_off] = req_din_q;
            dirty_d[req_idx]         = 1'b1;
          end
          if (first_q) hit_count_d  = hit_count_q + 32'd1;
          else         miss_count_d = miss_count_q + 32'd1;
          state_d = IDLE;
        end else begin
          // The re-compare after refill must report the request as a miss.
          first_d = 1'b0;
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (!sent_q) begin
          bus.mem_req_valid = 1'b1;
          bus.mem_req_we    = 1'b1;
          bus.mem_req_addr  = {tag_q[req_idx], req_idx, {(OFF_W+2){1'b0}}};
          bus.mem_req_wdata = data_q[req_idx];
          if (bus.mem_req_ready) sent_d = 1'b1;
        end else if (bus.mem_resp_valid) begin
          sent_d  = 1'b0;
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
        if (bus.mem_req_ready) state_d = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (bus.mem_resp_valid) begin
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          tag_d[req_idx]   = req_tag;
          data_d[req_idx]  = bus.mem_resp_rdata;
          state_d          = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      req_din_q    <= '0;
      req_we_q     <= 1'b0;
      first_q      <= 1'b0;
      sent_q       <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_din_q    <= req_din_d;
      req_we_q     <= req_we_d;
      first_q      <= first_d;
      sent_q       <= sent_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data storage need no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: doc/dcache_wb_ctrl.md
Name: dcache_wb_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU MEM stage and the line-wide multi-cycle data memory.
- Accepts one word load/store per handshake and reports hit/miss so the pipeline stall logic can freeze EX/MEM/WB.
- On a miss, evicts a dirty victim and refills the line from backing memory.
- Keeps hit/miss counters for performance measurement.

Parameters:
- NUM_SETS, 16, number of lines (power of 2); index width IDX_W = log2(NUM_SETS).
- LINE_WORDS, 4, 32-bit words per line (power of 2); line = LINE_WORDS*32 bits.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- is_input_valid  in  1  CPU request valid
- addr  in  ADDR_W  byte address; bits [1:0] ignored
- mem_read  in  1  load request
- mem_write  in  1  store request
- din  in  32  store data
- is_ready  out  1  controller can accept a request
- is_output_valid  out  1  request completes this cycle; dout valid for loads
- dout  out  32  load data
- is_hit  out  1  qualifies is_output_valid; 1 if first lookup hit
- mem_req_valid  out  1  backing-memory request valid
- mem_req_ready  in  1  backing memory accepts request
- mem_req_we  out  1  1 = line write (evict), 0 = line read (refill)
- mem_req_addr  out  ADDR_W  line-aligned byte address
- mem_req_wdata  out  LINE_WORDS*32  victim line
- mem_resp_valid  in  1  read data valid, or write complete
- mem_resp_rdata  in  LINE_WORDS*32  refill line; word 0 in LSBs
- hit_count  out  32  completed requests whose first lookup hit
- miss_count  out  32  completed requests whose first lookup missed

Behaviour:
- Address split: word offset addr[log2(LINE_WORDS)+1:2]; index is the next IDX_W bits; tag is the remaining upper bits.
- Per-line state: valid, dirty, tag, data.
- Reset, after the first edge with reset high and at any time mid-operation:
  - state=IDLE; all valid and dirty bits cleared; dirty data is discarded.
  - Request registers cleared; counters=0.
  - mem_req_valid=0 from the next cycle on; any in-flight memory response is ignored.
  - Outputs: is_ready=1, is_output_valid=0, is_hit=0, dout=0.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, WAIT_FILL.
- IDLE:
  - is_ready=1.
  - A request is accepted when is_input_valid && (mem_read || mem_write); addr, din and read/write are latched; next state COMPARE.
  - is_input_valid with neither read nor write set is ignored.
  - If read and write are both set, it is treated as a write.
- COMPARE:
  - is_ready=0. Hit = valid && tag match.
  - On hit: is_output_valid=1; dout = latched word (loads); store updates the word and sets dirty at the end of this cycle; next state IDLE.
  - Hit latency: accepted at edge N, is_output_valid high in cycle N+1.
  - On the first compare of a request, is_hit is the hit result.
  - On miss: a dirty victim goes to WRITEBACK, otherwise to ALLOCATE; is_output_valid=0.
- WRITEBACK:
  - Request: mem_req_valid=1, we=1, addr={victim tag, index, 0}, wdata=victim line.
  - Request is held stable until mem_req_ready; then wait for mem_resp_valid, then go to ALLOCATE.
- ALLOCATE:
  - Request: mem_req_valid=1, we=0, addr=line address of the latched request.
  - Request is held until mem_req_ready; then go to WAIT_FILL.
- WAIT_FILL: on mem_resp_valid, write the line (valid=1, dirty=0, new tag) and return to COMPARE.
  - The re-compare hits and completes with is_output_valid=1, is_hit=0.
  - A store then merges into the line and sets dirty.
- At most one memory request is outstanding. mem_req_valid deasserts the cycle after the handshake.
- Counters:
  - Each counter increments exactly once per completed request, in the is_output_valid cycle.
  - Counters wrap at 2^32.
- New requests are not accepted while not in IDLE. The requester must hold is_input_valid until it sees is_output_valid.

Test Plan:
- Reset, then load 0x0000_0040 (cold) -> ALLOCATE read addr 0x40; after fill, is_output_valid=1, is_hit=0, dout=mem word; miss_count=1.
- Repeat load 0x40 -> is_output_valid in cycle N+1, is_hit=1, hit_count=1, no mem_req_valid.
- Store 0xDEADBEEF to 0x44 (hit), then load 0x44 -> dout=0xDEADBEEF; line dirty; no memory write.
- Load 0x440 (same index, new tag, victim dirty) -> WRITEBACK first: we=1, addr 0x40, word1=0xDEADBEEF; then refill read of 0x440; completes with is_hit=0.
- Hold mem_req_ready=0 for 5 cycles during ALLOCATE -> mem_req_valid, addr and we stay constant; single request issued.
- Assert reset while in WAIT_FILL -> next cycle is_ready=1, mem_req_valid=0, counters 0; reload of 0x40 misses.
